// File: rtl/sad_block_engine.sv
// rtl/sad_block_engine.sv - pipelined 16x16 SAD engine with per-search minimum tracking
module sad_block_engine #(
    parameter int NUM_CAND = 81,
    parameter int IDX_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2047:0]    cur_blk,
    input  logic             ref_valid,
    input  logic [127:0]     ref_row,
    output logic             busy,
    output logic             sad_valid,
    output logic [15:0]      sad,
    output logic [IDX_W-1:0] cand_idx,
    output logic [15:0]      best_sad,
    output logic [IDX_W-1:0] best_idx,
    output logic             done
);
    localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NUM_CAND - 1);

    logic [3:0]       row_cnt;
    logic [IDX_W-1:0] cand_cnt;
    logic             all_in;
    logic             accept;
    logic [127:0]     cur_row;
    logic [15:0][7:0] diff_d;
    logic [11:0]      row_sum;
    logic [15:0]      final_sad;

    logic [15:0][7:0] s1_diff;
    logic             s1_valid, s1_first, s1_last;
    logic [IDX_W-1:0] s1_idx;
    logic [11:0]      s2_sum;
    logic             s2_valid, s2_first, s2_last;
    logic [IDX_W-1:0] s2_idx;
    logic [15:0]      acc;

    // all_in marks that every candidate row has been accepted; further rows are ignored
    assign accept = ref_valid && busy && !all_in && !start;

    always_comb begin
        cur_row = '0;
        for (int r = 0; r < 16; r++) begin
            if (row_cnt == 4'(r)) cur_row = cur_blk[2047-128*r -: 128];
        end
    end

    always_comb begin
        diff_d = '0;
        for (int p = 0; p < 16; p++) begin
            if (cur_row[127-8*p -: 8] > ref_row[127-8*p -: 8])
                diff_d[p] = cur_row[127-8*p -: 8] - ref_row[127-8*p -: 8];
            else
                diff_d[p] = ref_row[127-8*p -: 8] - cur_row[127-8*p -: 8];
        end
    end

    always_comb begin
        row_sum = '0;
        for (int p = 0; p < 16; p++) row_sum = row_sum + {4'd0, s1_diff[p]};
    end

    assign final_sad = s2_first ? {4'd0, s2_sum} : acc + {4'd0, s2_sum};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            sad_valid <= 1'b0;
            done      <= 1'b0;
            sad       <= '0;
            cand_idx  <= '0;
            best_sad  <= 16'hFFFF;
            best_idx  <= '0;
            row_cnt   <= '0;
            cand_cnt  <= '0;
            all_in    <= 1'b0;
            s1_diff   <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_idx    <= '0;
            s2_sum    <= '0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_idx    <= '0;
            acc       <= '0;
        end else if (start) begin
            // restart drops everything in flight, including a candidate finishing this cycle
            busy      <= 1'b1;
            sad_valid <= 1'b0;
            done      <= 1'b0;
            best_sad  <= 16'hFFFF;
            best_idx  <= '0;
            row_cnt   <= '0;
            cand_cnt  <= '0;
            all_in    <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
        end else begin
            sad_valid <= 1'b0;
            done      <= 1'b0;
            s1_valid  <= accept;
            if (accept) begin
                s1_diff  <= diff_d;
                s1_first <= (row_cnt == 4'd0);
                s1_last  <= (row_cnt == 4'd15);
                s1_idx   <= cand_cnt;
                row_cnt  <= row_cnt + 4'd1;
                if (row_cnt == 4'd15) begin
                    if (cand_cnt == LAST_CAND) all_in <= 1'b1;
                    else cand_cnt <= cand_cnt + IDX_W'(1);
                end
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= row_sum;
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_idx   <= s1_idx;
            end
            if (s2_valid) begin
                acc <= final_sad;
                if (s2_last) begin
                    sad       <= final_sad;
                    cand_idx  <= s2_idx;
                    sad_valid <= 1'b1;
                    if (final_sad < best_sad) begin
                        best_sad <= final_sad;
                        best_idx <= s2_idx;
                    end
                    if (s2_idx == LAST_CAND) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sad_block_engine.sv
// tb/tb_sad_block_engine.sv - directed self-checking bench for sad_block_engine
module tb_sad_block_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, ref_valid;
    logic [2047:0] cur_blk;
    logic [127:0]  ref_row;
    logic          busy_a, sv_a, done_a, busy_b, sv_b, done_b;
    logic [15:0]   sad_a, bsad_a, sad_b, bsad_b;
    logic [6:0]    idx_a, bidx_a, idx_b, bidx_b;

    sad_block_engine #(.NUM_CAND(3), .IDX_W(7)) dut_a (
        .clk(clk), .reset(reset), .start(start), .cur_blk(cur_blk),
        .ref_valid(ref_valid), .ref_row(ref_row), .busy(busy_a),
        .sad_valid(sv_a), .sad(sad_a), .cand_idx(idx_a),
        .best_sad(bsad_a), .best_idx(bidx_a), .done(done_a));

    sad_block_engine #(.NUM_CAND(4), .IDX_W(7)) dut_b (
        .clk(clk), .reset(reset), .start(start), .cur_blk(cur_blk),
        .ref_valid(ref_valid), .ref_row(ref_row), .busy(busy_b),
        .sad_valid(sv_b), .sad(sad_b), .cand_idx(idx_b),
        .best_sad(bsad_b), .best_idx(bidx_b), .done(done_b));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_row_cyc = 0;
    int a_sad[$], a_idx[$], a_cyc[$], b_sad[$], b_idx[$], b_cyc[$];
    int a_done_cnt = 0, b_done_cnt = 0, a_done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sv_a) begin a_sad.push_back(int'(sad_a)); a_idx.push_back(int'(idx_a)); a_cyc.push_back(cyc); end
        if (done_a) begin a_done_cnt++; a_done_cyc = cyc; end
        if (sv_b) begin b_sad.push_back(int'(sad_b)); b_idx.push_back(int'(idx_b)); b_cyc.push_back(cyc); end
        if (done_b) b_done_cnt++;
    end

    typedef struct packed {
        logic [7:0]       cur;
        logic [3:0][7:0]  refv;
        logic [3:0][15:0] exp_sad;
        logic [15:0]      exp_best;
        logic [6:0]       exp_bidx;
    } vec_t;
    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_q();
        a_sad.delete(); a_idx.delete(); a_cyc.delete();
        b_sad.delete(); b_idx.delete(); b_cyc.delete();
        a_done_cnt = 0; b_done_cnt = 0; a_done_cyc = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic feed_row(input logic [127:0] row);
        ref_valid = 1'b1;
        ref_row = row;
        @(posedge clk); #1;
        ref_valid = 1'b0;
        last_row_cyc = cyc;
    endtask

    task automatic feed_cand(input logic [127:0] row, input int gap);
        for (int r = 0; r < 16; r++) begin
            feed_row(row);
            if (gap > 0) idle($urandom_range(0, gap));
        end
    endtask

    task automatic do_start(input logic with_row);
        start = 1'b1;
        ref_valid = with_row;
        ref_row = {16{8'hFF}};
        @(posedge clk); #1;
        start = 1'b0;
        ref_valid = 1'b0;
    endtask

    task automatic wait_q(input logic sel_a, input int n, input int budget);
        int t = 0;
        while (((sel_a ? a_sad.size() : b_sad.size()) < n) && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check(sel_a ? "wait_a_timeout" : "wait_b_timeout", 32'(t < budget), 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ref_valid = 1'b0;
        cur_blk = '0; ref_row = '0;
        #1;
        check("rst_busy", 32'(busy_b), 0);
        check("rst_sad_valid", 32'(sv_b), 0);
        check("rst_done", 32'(done_b), 0);
        check("rst_sad", 32'(sad_b), 0);
        check("rst_cand_idx", 32'(idx_b), 0);
        check("rst_best_sad", 32'(bsad_b), 32'hFFFF);
        check("rst_best_idx", 32'(bidx_b), 0);
        #20; @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // all-equal search on the three-candidate instance
        clear_q();
        cur_blk = {256{8'h40}};
        do_start(1'b0);
        for (int c = 0; c < 3; c++) feed_cand({16{8'h40}}, 0);
        wait_q(1'b1, 3, 100);
        idle(5);
        check("eq_count", 32'(a_sad.size()), 3);
        for (int c = 0; c < 3; c++) begin
            check("eq_sad", 32'(a_sad[c]), 0);
            check("eq_idx", 32'(a_idx[c]), 32'(c));
        end
        check("eq_spacing1", 32'(a_cyc[1] - a_cyc[0]), 16);
        check("eq_spacing2", 32'(a_cyc[2] - a_cyc[1]), 16);
        check("eq_best_sad", 32'(bsad_a), 0);
        check("eq_best_idx", 32'(bidx_a), 0);
        check("eq_done_cnt", 32'(a_done_cnt), 1);
        check("eq_done_cyc", 32'(a_done_cyc), 32'(a_cyc[2]));
        check("eq_busy", 32'(busy_a), 0);

        // refv[0] is candidate 0 (rightmost element of each concatenation)
        vecs[0].cur = 8'h40; vecs[0].refv = {8'h47, 8'h42, 8'h42, 8'h45};
        vecs[0].exp_sad = {16'd1792, 16'd512, 16'd512, 16'd1280};
        vecs[0].exp_best = 16'd512; vecs[0].exp_bidx = 7'd1;
        vecs[1].cur = 8'h00; vecs[1].refv = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[1].exp_sad = {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        vecs[1].exp_best = 16'hFF00; vecs[1].exp_bidx = 7'd0;
        vecs[2].cur = 8'h80; vecs[2].refv = {8'h81, 8'h7F, 8'h90, 8'h70};
        vecs[2].exp_sad = {16'd256, 16'd256, 16'd4096, 16'd4096};
        vecs[2].exp_best = 16'd256; vecs[2].exp_bidx = 7'd2;

        for (int v = 0; v < 3; v++) begin
            clear_q();
            cur_blk = {256{vecs[v].cur}};
            do_start(1'b0);
            for (int c = 0; c < 4; c++) feed_cand({16{vecs[v].refv[c]}}, 0);
            wait_q(1'b0, 4, 100);
            check("tbl_latency", 32'(b_cyc[3] - last_row_cyc), 2);
            idle(5);
            check("tbl_count", 32'(b_sad.size()), 4);
            for (int c = 0; c < 4; c++) begin
                check("tbl_sad", 32'(b_sad[c]), 32'(vecs[v].exp_sad[c]));
                check("tbl_idx", 32'(b_idx[c]), 32'(c));
            end
            check("tbl_best_sad", 32'(bsad_b), 32'(vecs[v].exp_best));
            check("tbl_best_idx", 32'(bidx_b), 32'(vecs[v].exp_bidx));
            check("tbl_done_cnt", 32'(b_done_cnt), 1);
            check("tbl_busy", 32'(busy_b), 0);
        end

        // gapped rows, one pixel off by 9 per row
        clear_q();
        cur_blk = {256{8'h20}};
        do_start(1'b0);
        for (int c = 0; c < 4; c++) feed_cand({8'h29, {15{8'h20}}}, 3);
        wait_q(1'b0, 4, 600);
        idle(8);
        check("gap_count", 32'(b_sad.size()), 4);
        for (int c = 0; c < 4; c++) begin
            check("gap_sad", 32'(b_sad[c]), 144);
            check("gap_idx", 32'(b_idx[c]), 32'(c));
        end
        check("gap_done_cnt", 32'(b_done_cnt), 1);

        // start with ref_valid in the same cycle discards that row
        clear_q();
        cur_blk = {256{8'h40}};
        do_start(1'b1);
        feed_cand({16{8'h42}}, 0);
        wait_q(1'b0, 1, 50);
        idle(3);
        check("sv_same_count", 32'(b_sad.size()), 1);
        check("sv_same_sad", 32'(b_sad[0]), 512);
        check("sv_same_idx", 32'(b_idx[0]), 0);

        // restart after row 7 drops the partial candidate
        clear_q();
        do_start(1'b0);
        for (int r = 0; r < 8; r++) feed_row({16{8'hFF}});
        do_start(1'b0);
        feed_cand({16{8'h45}}, 0);
        wait_q(1'b0, 1, 50);
        idle(5);
        check("rs_count", 32'(b_sad.size()), 1);
        check("rs_sad", 32'(b_sad[0]), 1280);
        check("rs_idx", 32'(b_idx[0]), 0);
        check("rs_best", 32'(bsad_b), 1280);

        // async reset in the middle of row 10 of candidate 1
        do_start(1'b0);
        feed_cand({16{8'h47}}, 0);
        for (int r = 0; r < 10; r++) feed_row({16{8'h45}});
        check("pre_rst_best", 32'(bsad_b), 1792);
        ref_valid = 1'b1;
        ref_row = {16{8'h45}};
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy_b), 0);
        check("arst_sad", 32'(sad_b), 0);
        check("arst_best_sad", 32'(bsad_b), 32'hFFFF);
        check("arst_cand_idx", 32'(idx_b), 0);
        check("arst_sad_valid", 32'(sv_b), 0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        clear_q();
        for (int r = 0; r < 20; r++) feed_row({16{8'h45}});
        idle(6);
        check("post_rst_ignored", 32'(b_sad.size()), 0);
        check("post_rst_busy", 32'(busy_b), 0);
        do_start(1'b0);
        feed_cand({16{8'h47}}, 0);
        wait_q(1'b0, 1, 50);
        check("post_rst_sad", 32'(b_sad[0]), 1792);
        check("post_rst_idx", 32'(b_idx[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
